// File: rtl/relu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relu_pkg                                                             |
// | Shared types and helpers for the sequential P-lane ReLU block.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package relu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of set bits; callers zero-extend vectors of up to 64 bits.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

    function automatic int unsigned group_count(input int unsigned m, input int unsigned p);
        return m / p;
    endfunction

    function automatic int unsigned count_width(input int unsigned m);
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_vec_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relu_lane                                                            |
// | One lane: reconstruct x = r1 + e, ReLU on the carry, re-mask with r2.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module relu_lane #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_r1,
    input  logic [N-1:0] i_r2,
    input  logic [N-1:0] i_e,
    output logic [N-1:0] o_lane,
    output logic         o_pos
);

    logic [N:0]   w_sum;
    logic [N-1:0] w_relu;

    // Offset encoding: the carry out of r1 + e marks a non-negative value.
    assign w_sum  = {1'b0, i_r1} + {1'b0, i_e};
    assign w_relu = w_sum[N] ? w_sum[N-1:0] : '0;
    assign o_lane = w_relu + i_r2;
    assign o_pos  = w_sum[N];

endmodule
`default_nettype wire

// File: rtl/relu_vec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relu_vec                                                             |
// | Latches M secret-shared lanes and applies masked ReLU P lanes/cycle. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module relu_vec
    import relu_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 8,
    parameter int P = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2*M*N-1:0]         g_input,
    input  logic [M*N-1:0]           e_input,
    output logic [M*N-1:0]           o,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(M+1)-1:0]   pos_count
);

    localparam int c_groups = int'(group_count(M, P));
    localparam int c_cw     = int'(count_width(M));
    localparam int c_gw     = (c_groups > 1) ? $clog2(c_groups) : 1;

    if ((M % P != 0) || (P > 64)) begin : g_param_check
        $error("relu_vec: M must be a multiple of P and P must not exceed 64");
    end

    state_t             r_state_q, w_state_d;
    logic [2*M*N-1:0]   r_g_q, w_g_d;
    logic [M*N-1:0]     r_e_q, w_e_d;
    logic [M*N-1:0]     r_o_q, w_o_d;
    logic [c_cw-1:0]    r_pos_q, w_pos_d;
    logic [c_gw-1:0]    r_grp_q, w_grp_d;
    logic               r_busy_q, w_busy_d;
    logic               r_done_q, w_done_d;

    logic [N-1:0]       w_r1     [P];
    logic [N-1:0]       w_r2     [P];
    logic [N-1:0]       w_e      [P];
    logic [N-1:0]       w_lane_o [P];
    logic [P-1:0]       w_pos_vec;
    int                 w_lane0;

    assign w_lane0 = int'(r_grp_q) * P;

    for (genvar j = 0; j < P; j++) begin : g_lane
        assign w_r1[j] = r_g_q[(w_lane0 + j)*2*N + N +: N];
        assign w_r2[j] = r_g_q[(w_lane0 + j)*2*N +: N];
        assign w_e[j]  = r_e_q[(w_lane0 + j)*N +: N];

        relu_lane #(.N(N)) u_lane (
            .i_r1   (w_r1[j]),
            .i_r2   (w_r2[j]),
            .i_e    (w_e[j]),
            .o_lane (w_lane_o[j]),
            .o_pos  (w_pos_vec[j])
        );
    end

    always_comb begin
        w_state_d = r_state_q;
        w_g_d     = r_g_q;
        w_e_d     = r_e_q;
        w_o_d     = r_o_q;
        w_pos_d   = r_pos_q;
        w_grp_d   = r_grp_q;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_g_d     = g_input;
                    w_e_d     = e_input;
                    w_pos_d   = '0;
                    w_grp_d   = '0;
                    w_busy_d  = 1'b1;
                    w_state_d = RUN;
                end
            end
            RUN: begin
                for (int j = 0; j < P; j++) begin
                    w_o_d[(w_lane0 + j)*N +: N] = w_lane_o[j];
                end
                w_pos_d = r_pos_q + c_cw'(popcount(64'(w_pos_vec)));
                // Done is registered so it lines up with the DONE state cycle.
                if (r_grp_q == c_gw'(c_groups - 1)) begin
                    w_state_d = DONE;
                    w_done_d  = 1'b1;
                end else begin
                    w_grp_d = r_grp_q + c_gw'(1);
                end
            end
            DONE: begin
                w_busy_d  = 1'b0;
                w_state_d = IDLE;
            end
            default: begin
                w_busy_d  = 1'b0;
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_g_q     <= '0;
            r_e_q     <= '0;
            r_o_q     <= '0;
            r_pos_q   <= '0;
            r_grp_q   <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_g_q     <= w_g_d;
            r_e_q     <= w_e_d;
            r_o_q     <= w_o_d;
            r_pos_q   <= w_pos_d;
            r_grp_q   <= w_grp_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign o         = r_o_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;
    assign pos_count = r_pos_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_vec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_relu_vec                                                          |
// | Bench for relu_vec at N=8, M=4 with P=2, P=1 and P=4 instances.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_relu_vec;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int CW = $clog2(M + 1);

    logic               clk;
    logic               rst;
    logic               start;
    logic [2*M*N-1:0]   g_input;
    logic [M*N-1:0]     e_input;
    logic [M*N-1:0]     o_p2, o_p1, o_p4;
    logic               busy_p2, busy_p1, busy_p4;
    logic               done_p2, done_p1, done_p4;
    logic [CW-1:0]      pc_p2, pc_p1, pc_p4;

    int                 n_cmp;
    int                 n_bad;
    logic [M*N-1:0]     prev_o;

    relu_vec #(.N(N), .M(M), .P(2)) dut_p2 (
        .clk(clk), .rst(rst), .start(start), .g_input(g_input), .e_input(e_input),
        .o(o_p2), .busy(busy_p2), .done(done_p2), .pos_count(pc_p2)
    );
    relu_vec #(.N(N), .M(M), .P(1)) dut_p1 (
        .clk(clk), .rst(rst), .start(start), .g_input(g_input), .e_input(e_input),
        .o(o_p1), .busy(busy_p1), .done(done_p1), .pos_count(pc_p1)
    );
    relu_vec #(.N(N), .M(M), .P(4)) dut_p4 (
        .clk(clk), .rst(rst), .start(start), .g_input(g_input), .e_input(e_input),
        .o(o_p4), .busy(busy_p4), .done(done_p4), .pos_count(pc_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: reconstruct x as an integer sum, ReLU on the wrap, re-mask mod 2^N.
    function automatic void ref_model(input logic [2*M*N-1:0] g, input logic [M*N-1:0] e,
                                      output logic [M*N-1:0] o_exp, output int pc_exp);
        longint modulus;
        modulus = longint'(1) << N;
        o_exp   = '0;
        pc_exp  = 0;
        for (int i = 0; i < M; i++) begin
            longint r1, r2, ev, s, relu;
            r1 = longint'(g[2*N*i + N +: N]);
            r2 = longint'(g[2*N*i +: N]);
            ev = longint'(e[N*i +: N]);
            s  = r1 + ev;
            if (s >= modulus) begin
                relu   = s - modulus;
                pc_exp = pc_exp + 1;
            end else begin
                relu = 0;
            end
            o_exp[N*i +: N] = N'((relu + r2) % modulus);
        end
    endfunction

    task automatic randomize_inputs();
        g_input = {$urandom, $urandom};
        e_input = $urandom;
    endtask

    // Pulses start in cycle 0 and returns in the cycle where done_p2 is seen.
    task automatic run_op(output int done_cyc);
        done_cyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (done_p2) begin
                done_cyc = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; g_input = '0; e_input = '0;
        tick(); tick();
        n_cmp++; if (o_p2 !== '0) begin n_bad++; $display("FAIL reset_o: got %h want 0", o_p2); end
        n_cmp++; if (pc_p2 !== '0) begin n_bad++; $display("FAIL reset_pos: got %0d want 0", pc_p2); end
        n_cmp++; if (busy_p2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_p2); end
        n_cmp++; if (done_p2 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_p2); end
        rst = 1'b0;
        prev_o = '0;
        tick();
    endtask

    task automatic test_directed();
        int r1s [M] = '{200, 10, 255, 0};
        int es  [M] = '{100, 20, 1, 0};
        int r2s [M] = '{10, 77, 255, 5};
        logic [M*N-1:0] exp_o;
        int pc_exp;
        for (int i = 0; i < M; i++) begin
            g_input[2*N*i + N +: N] = N'(r1s[i]);
            g_input[2*N*i +: N]     = N'(r2s[i]);
            e_input[N*i +: N]       = N'(es[i]);
        end
        ref_model(g_input, e_input, exp_o, pc_exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        // cycle 2: only group 0 written, lanes 2..3 still hold previous values
        n_cmp++; if (o_p2 !== {prev_o[4*N-1:2*N], exp_o[2*N-1:0]}) begin
            n_bad++; $display("FAIL partial_o: got %h want %h", o_p2, {prev_o[4*N-1:2*N], exp_o[2*N-1:0]}); end
        n_cmp++; if (busy_p2 !== 1'b1 || done_p2 !== 1'b0) begin
            n_bad++; $display("FAIL run_flags: got busy=%b done=%b want busy=1 done=0", busy_p2, done_p2); end
        tick();
        n_cmp++; if (done_p2 !== 1'b1 || busy_p2 !== 1'b1) begin
            n_bad++; $display("FAIL done_cycle3: got done=%b busy=%b want 1 1", done_p2, busy_p2); end
        n_cmp++; if (o_p2[7:0] !== 8'd54) begin n_bad++; $display("FAIL pos_lane: got %0d want 54", o_p2[7:0]); end
        n_cmp++; if (o_p2[15:8] !== 8'd77) begin n_bad++; $display("FAIL neg_lane: got %0d want 77", o_p2[15:8]); end
        n_cmp++; if (o_p2[23:16] !== 8'd255) begin n_bad++; $display("FAIL wrap_lane: got %0d want 255", o_p2[23:16]); end
        n_cmp++; if (o_p2[31:24] !== 8'd5) begin n_bad++; $display("FAIL zero_lane: got %0d want 5", o_p2[31:24]); end
        n_cmp++; if (o_p2 !== exp_o) begin n_bad++; $display("FAIL directed_o: got %h want %h", o_p2, exp_o); end
        n_cmp++; if (pc_p2 !== 3'd2) begin n_bad++; $display("FAIL directed_pos: got %0d want 2", pc_p2); end
        tick();
        n_cmp++; if (done_p2 !== 1'b0 || busy_p2 !== 1'b0 || o_p2 !== exp_o) begin
            n_bad++; $display("FAIL idle_hold: got done=%b busy=%b o=%h want 0 0 %h", done_p2, busy_p2, o_p2, exp_o); end
        prev_o = exp_o;
    endtask

    task automatic test_random();
        logic [M*N-1:0] exp_o;
        int pc_exp;
        int dc;
        for (int k = 0; k < 8; k++) begin
            randomize_inputs();
            ref_model(g_input, e_input, exp_o, pc_exp);
            run_op(dc);
            n_cmp++; if (dc != 3) begin n_bad++; $display("FAIL rand_done_cycle[%0d]: got %0d want 3", k, dc); end
            n_cmp++; if (o_p2 !== exp_o) begin n_bad++; $display("FAIL rand_o[%0d]: got %h want %h", k, o_p2, exp_o); end
            n_cmp++; if (pc_p2 !== CW'(pc_exp)) begin n_bad++; $display("FAIL rand_pos[%0d]: got %0d want %0d", k, pc_p2, pc_exp); end
            tick();
            prev_o = exp_o;
        end
    endtask

    task automatic test_back_to_back();
        logic [2*M*N-1:0] g_a, g_b;
        logic [M*N-1:0]   e_a, e_b, exp_a, exp_b, o3, o7;
        logic [CW-1:0]    pc3, pc7;
        logic [8:0]       done_mask;
        logic             busy4;
        int               pc_a, pc_b;
        randomize_inputs(); g_a = g_input; e_a = e_input;
        randomize_inputs(); g_b = g_input; e_b = e_input;
        ref_model(g_a, e_a, exp_a, pc_a);
        ref_model(g_b, e_b, exp_b, pc_b);
        g_input = g_a; e_input = e_a;
        done_mask = '0; o3 = '0; o7 = '0; pc3 = '0; pc7 = '0; busy4 = 1'bx;
        for (int c = 0; c <= 8; c++) begin
            start = (c <= 5);
            if (c == 1) begin g_input = g_b; e_input = e_b; end
            done_mask[c] = done_p2;
            if (c == 3) begin o3 = o_p2; pc3 = pc_p2; end
            if (c == 4) busy4 = busy_p2;
            if (c == 7) begin o7 = o_p2; pc7 = pc_p2; end
            tick();
        end
        start = 1'b0;
        n_cmp++; if (done_mask !== 9'b010001000) begin n_bad++; $display("FAIL b2b_done_cycles: got %b want 010001000", done_mask); end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy: got %b want 0", busy4); end
        n_cmp++; if (o3 !== exp_a || pc3 !== CW'(pc_a)) begin
            n_bad++; $display("FAIL b2b_first: got o=%h pos=%0d want o=%h pos=%0d", o3, pc3, exp_a, pc_a); end
        n_cmp++; if (o7 !== exp_b || pc7 !== CW'(pc_b)) begin
            n_bad++; $display("FAIL b2b_second: got o=%h pos=%0d want o=%h pos=%0d", o7, pc7, exp_b, pc_b); end
        prev_o = exp_b;
    endtask

    task automatic test_reset_mid();
        logic [M*N-1:0] exp_o;
        int pc_exp;
        int dc;
        int done_seen;
        randomize_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (o_p2 !== '0 || pc_p2 !== '0) begin
            n_bad++; $display("FAIL midrst_clear: got o=%h pos=%0d want 0 0", o_p2, pc_p2); end
        n_cmp++; if (busy_p2 !== 1'b0 || done_p2 !== 1'b0) begin
            n_bad++; $display("FAIL midrst_flags: got busy=%b done=%b want 0 0", busy_p2, done_p2); end
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (done_p2) done_seen++;
            tick();
        end
        n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
        randomize_inputs();
        ref_model(g_input, e_input, exp_o, pc_exp);
        run_op(dc);
        n_cmp++; if (dc != 3 || o_p2 !== exp_o || pc_p2 !== CW'(pc_exp)) begin
            n_bad++; $display("FAIL midrst_recover: got cyc=%0d o=%h pos=%0d want 3 %h %0d", dc, o_p2, pc_p2, exp_o, pc_exp); end
        tick();
        prev_o = exp_o;
    endtask

    task automatic test_sweep();
        logic [M*N-1:0] exp_o, so1, so2, so4;
        logic [CW-1:0]  sp1, sp2, sp4;
        int pc_exp;
        int dc1, dc2, dc4;
        start = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        randomize_inputs();
        ref_model(g_input, e_input, exp_o, pc_exp);
        dc1 = -1; dc2 = -1; dc4 = -1;
        so1 = '0; so2 = '0; so4 = '0; sp1 = '0; sp2 = '0; sp4 = '0;
        for (int c = 0; c <= 10; c++) begin
            start = (c == 0);
            if (done_p1 && dc1 < 0) begin dc1 = c; so1 = o_p1; sp1 = pc_p1; end
            if (done_p2 && dc2 < 0) begin dc2 = c; so2 = o_p2; sp2 = pc_p2; end
            if (done_p4 && dc4 < 0) begin dc4 = c; so4 = o_p4; sp4 = pc_p4; end
            tick();
        end
        start = 1'b0;
        n_cmp++; if (dc1 != 5) begin n_bad++; $display("FAIL sweep_p1_cycle: got %0d want 5", dc1); end
        n_cmp++; if (dc2 != 3) begin n_bad++; $display("FAIL sweep_p2_cycle: got %0d want 3", dc2); end
        n_cmp++; if (dc4 != 2) begin n_bad++; $display("FAIL sweep_p4_cycle: got %0d want 2", dc4); end
        n_cmp++; if (so1 !== exp_o || sp1 !== CW'(pc_exp)) begin
            n_bad++; $display("FAIL sweep_p1_o: got o=%h pos=%0d want o=%h pos=%0d", so1, sp1, exp_o, pc_exp); end
        n_cmp++; if (so2 !== exp_o || sp2 !== CW'(pc_exp)) begin
            n_bad++; $display("FAIL sweep_p2_o: got o=%h pos=%0d want o=%h pos=%0d", so2, sp2, exp_o, pc_exp); end
        n_cmp++; if (so4 !== exp_o || sp4 !== CW'(pc_exp)) begin
            n_bad++; $display("FAIL sweep_p4_o: got o=%h pos=%0d want o=%h pos=%0d", so4, sp4, exp_o, pc_exp); end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        g_input = '0;
        e_input = '0;
        prev_o  = '0;
        #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
